// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Brief    : Shared widths, frame geometry and FSM encodings for the
//            frame-buffer write scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int PIXELS = H_RES * V_RES;

  typedef logic [0:0] frame_state_t;
  typedef logic [0:0] clr_state_t;

  // UART frame tracking
  localparam frame_state_t F_IDLE = 1'b0;
  localparam frame_state_t F_RX   = 1'b1;

  // Clear-screen sequencer
  localparam clr_state_t C_IDLE = 1'b0;
  localparam clr_state_t C_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Small show-ahead synchronous FIFO. Pushes are ignored when full
//            and pops when empty; simultaneous push and pop are allowed.
//            DEPTH must be a power of two, at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDR_W + DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_DEPTH = c_PTR_W'(0) + DEPTH[c_PTR_W:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  // Qualify requests against the current occupancy
  always_comb begin
    w_push_ok = push && (r_count != c_DEPTH);
    w_pop_ok  = pop && (r_count != '0);
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == c_DEPTH);
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_scheduler
// Brief    : Sole owner of the frame-buffer write port. Arbitrates UART pixel
//            stream > cursor queue > clear sequencer onto one registered
//            write port and tracks the UART frame position with idle resync.
// Revision : 1.0 - initial release
// ============================================================================
module fb_write_scheduler #(
  parameter int ADDR_W       = fb_pkg::ADDR_W,
  parameter int DATA_W       = fb_pkg::DATA_W,
  parameter int PIXELS       = fb_pkg::PIXELS,
  parameter int IDLE_TIMEOUT = 5_000_000,
  parameter int CUR_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_valid,
  input  logic [DATA_W-1:0] uart_data,
  input  logic              cur_req,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [DATA_W-1:0] cur_data,
  output logic              cur_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              bram_wren,
  output logic [ADDR_W-1:0] bram_wraddr,
  output logic [DATA_W-1:0] bram_data,
  output logic [ADDR_W-1:0] frame_addr,
  output logic              frame_done,
  output logic              resync,
  output logic [7:0]        drop_cnt
);

  import fb_pkg::*;

  localparam int                 c_IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam int                 c_CNT_W    = $clog2(CUR_DEPTH) + 1;
  localparam logic [ADDR_W-1:0]  c_LAST_PIX = ADDR_W'(PIXELS - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(IDLE_TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(CUR_DEPTH);

  frame_state_t        r_frame_state, w_frame_state_nxt;
  clr_state_t          r_clr_state, w_clr_state_nxt;

  logic [ADDR_W-1:0]   r_frame_addr;
  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [DATA_W-1:0]   r_clr_color;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_wraddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_frame_done;
  logic                r_resync;
  logic [7:0]          r_drop_cnt;

  logic                w_frame_rx;
  logic                w_wrap;
  logic                w_timeout;
  logic                w_push;
  logic                w_push_drop;
  logic                w_pop;
  logic                w_pop_drop;
  logic                w_cur_grant;
  logic                w_clr_grant;
  logic                w_clr_last;
  logic [ADDR_W-1:0]   w_pop_addr;
  logic [DATA_W-1:0]   w_pop_data;
  logic [1:0]          w_drop_inc;
  logic [8:0]          w_drop_sum;

  logic [ADDR_W+DATA_W-1:0] w_fifo_dout;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [c_CNT_W-1:0]       w_fifo_count;

  sync_fifo #(
    .DEPTH (CUR_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_cur_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({cur_addr, cur_data}),
    .pop       (w_pop),
    .pop_data  (w_fifo_dout),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign cur_ready = (w_fifo_count < c_DEPTH);

  // Arbitration: UART always wins; the queue head pops whenever UART is idle
  // and an out-of-frame address is discarded rather than written, which leaves
  // the slot free for the clear sequencer.
  always_comb begin
    w_pop_addr  = w_fifo_dout[ADDR_W+DATA_W-1:DATA_W];
    w_pop_data  = w_fifo_dout[DATA_W-1:0];
    w_push      = cur_req && !w_fifo_full;
    w_push_drop = cur_req && w_fifo_full;
    w_pop       = !uart_valid && !w_fifo_empty;
    w_cur_grant = w_pop && (w_pop_addr <= c_LAST_PIX);
    w_pop_drop  = w_pop && (w_pop_addr > c_LAST_PIX);
    w_wrap      = uart_valid && (r_frame_addr == c_LAST_PIX);
    w_timeout   = w_frame_rx && !uart_valid && (r_idle_cnt == c_IDLE_MAX);
    w_clr_last  = (r_clr_addr == c_LAST_PIX);
    w_drop_inc  = {1'b0, w_push_drop} + {1'b0, w_pop_drop};
    w_drop_sum  = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};
  end

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_frame_state <= F_IDLE;
    else       r_frame_state <= w_frame_state_nxt;
  end

  // Frame FSM next state: enter on the first byte, leave on wrap or timeout
  always_comb begin
    w_frame_state_nxt = r_frame_state;
    case (r_frame_state)
      F_IDLE:  if (uart_valid && !w_wrap) w_frame_state_nxt = F_RX;
      F_RX:    if (w_wrap || w_timeout)   w_frame_state_nxt = F_IDLE;
      default: w_frame_state_nxt = F_IDLE;
    endcase
  end

  // Frame FSM outputs: idle counting is only armed mid-frame
  always_comb begin
    w_frame_rx = (r_frame_state == F_RX);
  end

  // Frame position and idle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_addr <= '0;
      r_idle_cnt   <= '0;
    end else begin
      if (uart_valid)     r_frame_addr <= w_wrap ? '0 : r_frame_addr + 1'b1;
      else if (w_timeout) r_frame_addr <= '0;

      if (uart_valid || !w_frame_rx || w_timeout) r_idle_cnt <= '0;
      else                                         r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // Clear FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_clr_state <= C_IDLE;
    else       r_clr_state <= w_clr_state_nxt;
  end

  // Clear FSM next state: a start request during a running clear is ignored
  always_comb begin
    w_clr_state_nxt = r_clr_state;
    case (r_clr_state)
      C_IDLE:  if (clr_start)                w_clr_state_nxt = C_RUN;
      C_RUN:   if (w_clr_grant && w_clr_last) w_clr_state_nxt = C_IDLE;
      default: w_clr_state_nxt = C_IDLE;
    endcase
  end

  // Clear FSM outputs: the sequencer takes only slots nobody else wants
  always_comb begin
    clr_busy    = (r_clr_state == C_RUN);
    w_clr_grant = clr_busy && !uart_valid && !w_cur_grant;
  end

  // Clear address and fill colour, captured when a start is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else if ((r_clr_state == C_IDLE) && clr_start) begin
      r_clr_addr  <= '0;
      r_clr_color <= clr_color;
    end else if (w_clr_grant) begin
      r_clr_addr  <= w_clr_last ? '0 : r_clr_addr + 1'b1;
    end
  end

  // Registered write port, frame pulses and saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wren       <= 1'b0;
      r_wraddr     <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_resync     <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_wren       <= uart_valid || w_cur_grant || w_clr_grant;
      r_frame_done <= w_wrap;
      r_resync     <= w_timeout;
      r_drop_cnt   <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (uart_valid) begin
        r_wraddr <= r_frame_addr;
        r_wdata  <= uart_data;
      end else if (w_cur_grant) begin
        r_wraddr <= w_pop_addr;
        r_wdata  <= w_pop_data;
      end else if (w_clr_grant) begin
        r_wraddr <= r_clr_addr;
        r_wdata  <= r_clr_color;
      end else begin
        r_wraddr <= '0;
        r_wdata  <= '0;
      end
    end
  end

  assign bram_wren   = r_wren;
  assign bram_wraddr = r_wraddr;
  assign bram_data   = r_wdata;
  assign frame_addr  = r_frame_addr;
  assign frame_done  = r_frame_done;
  assign resync      = r_resync;
  assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_scheduler
// Brief    : Scoreboard bench for fb_write_scheduler with a reduced frame
//            size and idle timeout so complete frames and clears fit in a
//            short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_write_scheduler;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 8;
  localparam int PIXELS       = 64;
  localparam int IDLE_TIMEOUT = 100;
  localparam int CUR_DEPTH    = 4;

  logic              CLOCK_50   = 1'b0;
  logic              reset      = 1'b1;
  logic              uart_valid = 1'b0;
  logic [DATA_W-1:0] uart_data  = '0;
  logic              cur_req    = 1'b0;
  logic [ADDR_W-1:0] cur_addr   = '0;
  logic [DATA_W-1:0] cur_data   = '0;
  logic              clr_start  = 1'b0;
  logic [DATA_W-1:0] clr_color  = '0;
  logic              cur_ready;
  logic              clr_busy;
  logic              bram_wren;
  logic [ADDR_W-1:0] bram_wraddr;
  logic [DATA_W-1:0] bram_data;
  logic [ADDR_W-1:0] frame_addr;
  logic              frame_done;
  logic              resync;
  logic [7:0]        drop_cnt;

  fb_write_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIXELS(PIXELS),
    .IDLE_TIMEOUT(IDLE_TIMEOUT), .CUR_DEPTH(CUR_DEPTH)
  ) dut (
    .clk(CLOCK_50), .reset(reset),
    .uart_valid(uart_valid), .uart_data(uart_data),
    .cur_req(cur_req), .cur_addr(cur_addr), .cur_data(cur_data), .cur_ready(cur_ready),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .bram_wren(bram_wren), .bram_wraddr(bram_wraddr), .bram_data(bram_data),
    .frame_addr(frame_addr), .frame_done(frame_done), .resync(resync), .drop_cnt(drop_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              done;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int resync_cnt = 0;

  // Scoreboard: every write must match the oldest expected entry
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (resync === 1'b1) resync_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (bram_wren === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%0d data=%h done=%b, expected no write",
                 bram_wraddr, bram_data, frame_done);
      end else begin
        e = exp_q.pop_front();
        if ({bram_wraddr, bram_data, frame_done} !== e) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h done=%b, expected addr=%0d data=%h done=%b",
                   bram_wraddr, bram_data, frame_done, e.addr, e.data, e.done);
        end
      end
    end else if (frame_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_done_without_write got frame_done=1 bram_wren=%b, expected 0", bram_wren);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; uart_valid = 1'b0; cur_req = 1'b0; clr_start = 1'b0;
    repeat (3) step();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bram_wren !== 1'b0)  begin errors++; $display("FAIL reset_wren got %b, expected 0", bram_wren); end
    checks++; if (bram_wraddr !== '0)  begin errors++; $display("FAIL reset_wraddr got %0d, expected 0", bram_wraddr); end
    checks++; if (frame_addr !== '0)   begin errors++; $display("FAIL reset_frame_addr got %0d, expected 0", frame_addr); end
    checks++; if ({frame_done, resync, clr_busy} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b, expected 000", {frame_done, resync, clr_busy}); end
    checks++; if (drop_cnt !== 8'd0)   begin errors++; $display("FAIL reset_drop_cnt got %0d, expected 0", drop_cnt); end
    checks++; if (cur_ready !== 1'b1)  begin errors++; $display("FAIL reset_cur_ready got %b, expected 1", cur_ready); end
  endtask

  task automatic test_uart_wrap();
    int d0;
    do_reset();
    d0 = done_cnt;
    for (int i = 0; i < PIXELS; i++) begin
      if (i == PIXELS / 2) begin
        checks++;
        if (frame_addr !== ADDR_W'(i)) begin errors++; $display("FAIL wrap_mid_frame_addr got %0d, expected %0d", frame_addr, i); end
      end
      exp_q.push_back('{addr: ADDR_W'(i), data: DATA_W'(i), done: (i == PIXELS - 1)});
      uart_valid = 1'b1; uart_data = DATA_W'(i);
      step();
      uart_valid = 1'b0;
      step(); step();
    end
    wait_drain(10);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain got %0d pending, expected 0", exp_q.size()); end
    checks++; if (frame_addr !== '0)  begin errors++; $display("FAIL wrap_frame_addr got %0d, expected 0", frame_addr); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wrap_done_count got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_idle_resync();
    int r0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: DATA_W'(8'h30 + i), done: 1'b0});
      uart_valid = 1'b1; uart_data = DATA_W'(8'h30 + i);
      step();
      uart_valid = 1'b0;
      step(); step();
    end
    r0 = resync_cnt;
    checks++; if (frame_addr !== ADDR_W'(10)) begin errors++; $display("FAIL resync_pre_addr got %0d, expected 10", frame_addr); end
    repeat (IDLE_TIMEOUT - 5) step();
    checks++; if (resync_cnt != r0) begin errors++; $display("FAIL resync_early got %0d pulses, expected 0", resync_cnt - r0); end
    repeat (25) step();
    checks++; if (resync_cnt - r0 != 1) begin errors++; $display("FAIL resync_count got %0d, expected 1", resync_cnt - r0); end
    checks++; if (frame_addr !== '0)    begin errors++; $display("FAIL resync_frame_addr got %0d, expected 0", frame_addr); end
    exp_q.push_back('{addr: '0, data: 8'h55, done: 1'b0});
    uart_valid = 1'b1; uart_data = 8'h55;
    step();
    uart_valid = 1'b0;
    step();
    checks++; if (exp_q.size() != 0)        begin errors++; $display("FAIL resync_next_byte got %0d pending, expected 0", exp_q.size()); end
    checks++; if (frame_addr !== ADDR_W'(1)) begin errors++; $display("FAIL resync_next_addr got %0d, expected 1", frame_addr); end
  endtask

  task automatic test_contention();
    do_reset();
    exp_q.push_back('{addr: '0, data: 8'hA5, done: 1'b0});
    exp_q.push_back('{addr: ADDR_W'(40), data: 8'hE0, done: 1'b0});
    uart_valid = 1'b1; uart_data = 8'hA5;
    cur_req = 1'b1; cur_addr = ADDR_W'(40); cur_data = 8'hE0;
    step();
    uart_valid = 1'b0; cur_req = 1'b0;
    checks++;
    if ({bram_wren, bram_wraddr, bram_data} !== {1'b1, ADDR_W'(0), 8'hA5}) begin
      errors++; $display("FAIL contention_n1 got wren=%b addr=%0d data=%h, expected 1/0/a5", bram_wren, bram_wraddr, bram_data);
    end
    step();
    checks++;
    if ({bram_wren, bram_wraddr, bram_data} !== {1'b1, ADDR_W'(40), 8'hE0}) begin
      errors++; $display("FAIL contention_n2 got wren=%b addr=%0d data=%h, expected 1/40/e0", bram_wren, bram_wraddr, bram_data);
    end
    step();
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL contention_drop got %0d, expected 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back('{addr: ADDR_W'(i), data: DATA_W'(8'h10 + i), done: 1'b0});
    for (int i = 0; i < 4; i++) exp_q.push_back('{addr: ADDR_W'(20 + i), data: DATA_W'(8'hC0 + i), done: 1'b0});
    for (int i = 0; i < 6; i++) begin
      uart_valid = 1'b1; uart_data = DATA_W'(8'h10 + i);
      cur_req = 1'b1; cur_addr = ADDR_W'(20 + i); cur_data = DATA_W'(8'hC0 + i);
      if (i == 4) begin
        checks++; if (cur_ready !== 1'b0) begin errors++; $display("FAIL overflow_ready_full got %b, expected 0", cur_ready); end
      end
      step();
    end
    uart_valid = 1'b0; cur_req = 1'b0;
    wait_drain(20);
    step();
    checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL overflow_drain got %0d pending, expected 0", exp_q.size()); end
    checks++; if (drop_cnt !== 8'd2)  begin errors++; $display("FAIL overflow_drop got %0d, expected 2", drop_cnt); end
    checks++; if (cur_ready !== 1'b1) begin errors++; $display("FAIL overflow_ready_after got %b, expected 1", cur_ready); end
  endtask

  task automatic test_invalid_addr();
    int w0;
    do_reset();
    w0 = wr_cnt;
    cur_req = 1'b1; cur_addr = ADDR_W'(PIXELS); cur_data = 8'h77;
    step();
    cur_req = 1'b0;
    repeat (5) step();
    checks++; if (wr_cnt != w0)       begin errors++; $display("FAIL invalid_write got %0d writes, expected 0", wr_cnt - w0); end
    checks++; if (drop_cnt !== 8'd1)  begin errors++; $display("FAIL invalid_drop got %0d, expected 1", drop_cnt); end
    checks++; if (cur_ready !== 1'b1) begin errors++; $display("FAIL invalid_ready got %b, expected 1", cur_ready); end
  endtask

  task automatic test_clear_full();
    do_reset();
    for (int i = 0; i < PIXELS; i++) exp_q.push_back('{addr: ADDR_W'(i), data: 8'h3C, done: 1'b0});
    clr_start = 1'b1; clr_color = 8'h3C;
    step();
    clr_start = 1'b0; clr_color = 8'hFF;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_start got %b, expected 1", clr_busy); end
    repeat (PIXELS - 1) step();
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_before_last got %b, expected 1", clr_busy); end
    step();
    checks++;
    if ({clr_busy, bram_wren, bram_wraddr} !== {1'b0, 1'b1, ADDR_W'(PIXELS - 1)}) begin
      errors++; $display("FAIL clear_last got busy=%b wren=%b addr=%0d, expected 0/1/%0d", clr_busy, bram_wren, bram_wraddr, PIXELS - 1);
    end
    step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL clear_drain got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_clear_interrupt();
    int w0;
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back('{addr: ADDR_W'(i), data: 8'h1C, done: 1'b0});
    exp_q.push_back('{addr: '0, data: 8'h99, done: 1'b0});
    for (int i = 10; i < 40; i++) exp_q.push_back('{addr: ADDR_W'(i), data: 8'h1C, done: 1'b0});
    clr_start = 1'b1; clr_color = 8'h1C;
    step();
    clr_start = 1'b0;
    repeat (10) step();
    uart_valid = 1'b1; uart_data = 8'h99;
    step();
    uart_valid = 1'b0;
    repeat (30) step();
    reset = 1'b1;
    step();
    checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL interrupt_sequence got %0d pending, expected 0", exp_q.size()); end
    checks++; if (clr_busy !== 1'b0)  begin errors++; $display("FAIL interrupt_busy got %b, expected 0", clr_busy); end
    checks++; if (cur_ready !== 1'b1) begin errors++; $display("FAIL interrupt_ready got %b, expected 1", cur_ready); end
    w0 = wr_cnt;
    step();
    reset = 1'b0;
    repeat (20) step();
    checks++; if (wr_cnt != w0) begin errors++; $display("FAIL interrupt_no_writes got %0d writes, expected 0", wr_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_uart_wrap();
    test_idle_resync();
    test_contention();
    test_overflow();
    test_invalid_addr();
    test_clear_full();
    test_clear_interrupt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
